control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 141 ++++++++++++++
 tb/tb_control_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: multi-step datapath sequencer with a Moore FSM (IDLE/T1/T2/T3).
// Ports: CLKb/RSTb clock and async active-low reset, Run/DIN instruction request,
// FN/Ain/Gin/Gout ALU control, Rin/Rout one-hot register selects, Extern bus drive,
// Done/Err/Busy status, and Tstep current step.
module control_sequencer #(
  parameter int N = 10
) (
  input  logic         CLKb,
  input  logic         RSTb,
  input  logic         Run,
  input  logic [N-1:0] DIN,
  output logic [3:0]   FN,
  output logic         Ain,
  output logic         Gin,
  output logic         Gout,
  output logic [7:0]   Rin,
  output logic [7:0]   Rout,
  output logic         Extern,
  output logic         Done,
  output logic         Err,
  output logic         Busy,
  output logic [1:0]   Tstep
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] ir;

  logic [3:0] op;
  logic [7:0] rx_oh;
  logic [7:0] ry_oh;
  logic       is_ld;
  logic       is_mov;
  logic       is_bin;
  logic       is_un;
  logic       is_ill;

  assign op    = ir[9:6];
  assign rx_oh = 8'b1 << ir[5:3];
  assign ry_oh = 8'b1 << ir[2:0];

  always_comb begin
    is_ld  = 1'b0;
    is_mov = 1'b0;
    is_bin = 1'b0;
    is_un  = 1'b0;
    is_ill = 1'b0;
    unique case (op)
      4'b0000: is_ld  = 1'b1;
      4'b0001: is_mov = 1'b1;
      4'b0010, 4'b0011, 4'b0110,
      4'b0111, 4'b1000: is_bin = 1'b1;
      4'b0100, 4'b0101, 4'b1001,
      4'b1010, 4'b1011: is_un  = 1'b1;
      default: is_ill = 1'b1;
    endcase
  end

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && Run) ir <= DIN;
    end
  end

  always_comb begin
    state_nx = IDLE;
    FN       = 4'b0000;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    Rin      = 8'h00;
    Rout     = 8'h00;
    Extern   = 1'b0;
    Done     = 1'b0;
    Err      = 1'b0;
    Busy     = (state != IDLE);
    Tstep    = state;
    if (Busy) FN = op;
    unique case (state)
      IDLE: if (Run) state_nx = T1;
      T1: begin
        unique case (1'b1)
          is_ld: begin
            Extern = 1'b1;
            Rin    = rx_oh;
            Done   = 1'b1;
          end
          is_mov: begin
            Rout = ry_oh;
            Rin  = rx_oh;
            Done = 1'b1;
          end
          is_bin: begin
            Rout     = rx_oh;
            Ain      = 1'b1;
            state_nx = T2;
          end
          is_un: begin
            Rout     = ry_oh;
            Gin      = 1'b1;
            state_nx = T2;
          end
          is_ill: begin
            Done = 1'b1;
            Err  = 1'b1;
          end
          default: ;
        endcase
      end
      T2: begin
        if (is_bin) begin
          Rout     = ry_oh;
          Gin      = 1'b1;
          state_nx = T3;
        end else begin
          Gout = 1'b1;
          Rin  = rx_oh;
          Done = 1'b1;
        end
      end
      T3: begin
        Gout = 1'b1;
        Rin  = rx_oh;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench for control_sequencer.
// A queue of expected per-step outputs, built from the instruction table, is compared every cycle.
module tb_control_sequencer;

  logic       CLKb;
  logic       RSTb;
  logic       Run;
  logic [9:0] DIN;
  logic [3:0] FN;
  logic       Ain, Gin, Gout;
  logic [7:0] Rin, Rout;
  logic       Extern, Done, Err, Busy;
  logic [1:0] Tstep;

  int checks = 0;
  int errors = 0;

  control_sequencer #(.N(10)) dut (
    .CLKb(CLKb), .RSTb(RSTb), .Run(Run), .DIN(DIN),
    .FN(FN), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .Rin(Rin), .Rout(Rout), .Extern(Extern),
    .Done(Done), .Err(Err), .Busy(Busy), .Tstep(Tstep)
  );

  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  typedef struct packed {
    logic [1:0] tstep;
    logic [3:0] fn;
    logic       busy;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       ext;
    logic       done;
    logic       err;
    logic [7:0] rin;
    logic [7:0] rout;
  } obs_t;

  obs_t act_o;
  obs_t exp_o;
  obs_t q[$];

  assign act_o = '{Tstep, FN, Busy, Ain, Gin, Gout, Extern,
                   Done, Err, Rin, Rout};

  function automatic obs_t mk(int t, logic [3:0] f, logic a, logic g,
                              logic go, logic e, logic [7:0] ri,
                              logic [7:0] ro, logic d, logic er);
    obs_t o;
    o.tstep = 2'(t);
    o.fn    = f;
    o.busy  = 1'b1;
    o.ain   = a;
    o.gin   = g;
    o.gout  = go;
    o.ext   = e;
    o.done  = d;
    o.err   = er;
    o.rin   = ri;
    o.rout  = ro;
    return o;
  endfunction

  // Expand one instruction word into its sequence of step outputs.
  function automatic void push_instr(logic [9:0] w);
    logic [3:0] op;
    logic [7:0] xh, yh;
    op = w[9:6];
    xh = 8'b1 << w[5:3];
    yh = 8'b1 << w[2:0];
    if (op == 4'd0) begin
      q.push_back(mk(1, op, 0, 0, 0, 1, xh, 8'h00, 1, 0));
    end else if (op == 4'd1) begin
      q.push_back(mk(1, op, 0, 0, 0, 0, xh, yh, 1, 0));
    end else if (op inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd8}) begin
      q.push_back(mk(1, op, 1, 0, 0, 0, 8'h00, xh, 0, 0));
      q.push_back(mk(2, op, 0, 1, 0, 0, 8'h00, yh, 0, 0));
      q.push_back(mk(3, op, 0, 0, 1, 0, xh, 8'h00, 1, 0));
    end else if (op inside {4'd4, 4'd5, 4'd9, 4'd10, 4'd11}) begin
      q.push_back(mk(1, op, 0, 1, 0, 0, 8'h00, yh, 0, 0));
      q.push_back(mk(2, op, 0, 0, 1, 0, xh, 8'h00, 1, 0));
    end else begin
      q.push_back(mk(1, op, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1));
    end
  endfunction

  // Model: empty queue means idle; an instruction is taken only from idle.
  always @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) q.delete();
    else if (q.size() > 0) void'(q.pop_front());
    else if (Run) push_instr(DIN);
  end

  always @(negedge CLKb) begin
    exp_o = (q.size() > 0) ? q[0] : '0;
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL model t=%0t got %h want %h", $time, act_o, exp_o);
    end
    checks++;
    if ((32'(Extern) + 32'(Gout) + $countones(Rout)) > 1 ||
        $countones(Rin) > 1) begin
      errors++;
      $display("FAIL excl t=%0t rout=%h rin=%h ext=%b gout=%b",
               $time, Rout, Rin, Extern, Gout);
    end
  end

  task automatic lit(string nm, logic [31:0] act, logic [31:0 ] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic go(logic [9:0] w);
    @(negedge CLKb);
    #1 Run = 1'b1;
    DIN = w;
    @(posedge CLKb);
    #1 Run = 1'b0;
  endtask

  logic [9:0] words[10] = '{10'h0D1, 10'h10F, 10'h2F3, 10'h301, 10'h052,
                            10'h09B, 10'h1E5, 10'h288, 10'h15A, 10'h238};

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    RSTb = 1'b0;
    Run  = 1'b0;
    DIN  = '0;
    #2;
    lit("reset_all", 32'(act_o), 32'h0);
    lit("reset_tstep", 32'(Tstep), 32'd0);
    repeat (2) @(negedge CLKb);
    #1 RSTb = 1'b1;

    // LD R3 with immediate on the following cycle
    go(10'h018);
    DIN = 10'h155;
    @(negedge CLKb);
    lit("ld_ext", 32'(Extern), 32'd1);
    lit("ld_rin", 32'(Rin), 32'h08);
    lit("ld_done", 32'(Done), 32'd1);
    lit("ld_tstep", 32'(Tstep), 32'd1);
    @(negedge CLKb);
    lit("ld_idle", 32'(Tstep), 32'd0);

    // ADD R1,R2
    go(10'h08A);
    @(negedge CLKb);
    lit("add_t1_rout", 32'(Rout), 32'h02);
    lit("add_t1_ain", 32'(Ain), 32'd1);
    @(negedge CLKb);
    lit("add_t2_rout", 32'(Rout), 32'h04);
    lit("add_t2_gin", 32'(Gin), 32'd1);
    lit("add_t2_fn", 32'(FN), 32'h2);
    @(negedge CLKb);
    lit("add_t3_gout", 32'(Gout), 32'd1);
    lit("add_t3_rin", 32'(Rin), 32'h02);
    lit("add_t3_done", 32'(Done), 32'd1);

    // LSL R4,R6
    go(10'h266);
    @(negedge CLKb);
    lit("lsl_t1_rout", 32'(Rout), 32'h40);
    lit("lsl_t1_gin", 32'(Gin), 32'd1);
    lit("lsl_t1_fn", 32'(FN), 32'h9);
    lit("lsl_t1_ain", 32'(Ain), 32'd0);
    @(negedge CLKb);
    lit("lsl_t2_gout", 32'(Gout), 32'd1);
    lit("lsl_t2_rin", 32'(Rin), 32'h10);
    lit("lsl_t2_done", 32'(Done), 32'd1);

    // Illegal opcode
    go(10'h3C0);
    @(negedge CLKb);
    lit("ill_done", 32'(Done), 32'd1);
    lit("ill_err", 32'(Err), 32'd1);
    lit("ill_en", 32'({Rin, Rout, Extern, Gout}), 32'h0);
    @(negedge CLKb);
    lit("ill_idle", 32'({Tstep, Err}), 32'h0);

    // Run held high: MOV R5,R0 then ADD
    @(negedge CLKb);
    #1 Run = 1'b1;
    DIN = 10'h068;
    @(negedge CLKb);
    lit("mov_t1_rout", 32'(Rout), 32'h01);
    lit("mov_t1_rin", 32'(Rin), 32'h20);
    lit("mov_t1_done", 32'(Done), 32'd1);
    #1 DIN = 10'h08A;
    @(negedge CLKb);
    lit("held_idle", 32'({Tstep, Busy}), 32'h0);
    @(negedge CLKb);
    lit("held_add_t1", 32'({Tstep, Rout, Ain}), 32'({2'd1, 8'h02, 1'b1}));
    #1 Run = 1'b0;
    repeat (3) @(negedge CLKb);

    foreach (words[i]) begin
      go(words[i]);
      repeat (4) @(negedge CLKb);
    end

    // Reset during T2 of ADD
    go(10'h08A);
    @(posedge CLKb);
    #2 RSTb = 1'b0;
    #1;
    lit("rst_mid_all", 32'(act_o), 32'h0);
    @(negedge CLKb);
    #1 RSTb = 1'b1;
    repeat (2) @(negedge CLKb);
    go(10'h238);
    @(negedge CLKb);
    lit("post_rst_t1", 32'({Tstep, FN, Rout, Ain}),
        32'({2'd1, 4'h8, 8'h80, 1'b1}));
    repeat (4) @(negedge CLKb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
